// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the SISC datapath.
// Memory handshake with bounded wait, branch evaluation, sticky HALT/FAULT.
module ctrl_seq #(
  parameter int CC_W        = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 8
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [3:0]      opcode,
  input  logic [CC_W-1:0] mm,
  input  logic [CC_W-1:0] stat,
  input  logic            run,
  input  logic            mem_ack,
  output logic            rf_we,
  output logic [1:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic            br_sel,
  output logic            rb_sel,
  output logic            ir_load,
  output logic            pc_sel,
  output logic            pc_write,
  output logic            pc_rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    START     = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    FAULT     = 3'd7
  } st_t;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

  st_t               st;
  st_t               st_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_nxt;
  logic [WAIT_W-1:0] cnt_inc;
  logic              time_out;
  logic              hit;
  logic              uncond;
  logic              is_br;
  logic              is_pos;
  logic              taken;
  logic              is_ldst;
  logic              is_imm;

  assign state    = st;
  assign hit      = |(mm & stat);
  assign uncond   = (mm == '0);
  assign is_br    = opcode inside {OP_BRA, OP_BRR, OP_BNE, OP_BNR};
  assign is_pos   = (opcode == OP_BRA) || (opcode == OP_BRR);
  assign taken    = is_br & (uncond | (is_pos ? hit : ~hit));
  assign is_ldst  = (opcode == OP_LOD) || (opcode == OP_STR);
  assign is_imm   = (mm == CC_W'(8));
  assign cnt_inc  = (cnt == TMO) ? cnt : cnt + WAIT_W'(1);
  // timeout fires on the wait cycle that brings the count to the limit
  assign time_out = (cnt_inc == TMO);

  always_comb begin
    st_nxt   = st;
    cnt_nxt  = cnt;
    rf_we    = 1'b0;
    alu_op   = 2'b00;
    wb_sel   = 2'b00;
    br_sel   = 1'b0;
    rb_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (st)
      START: begin
        pc_rst = 1'b1;
        if (run) st_nxt = FETCH;
      end
      FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            cnt_nxt  = '0;
            st_nxt   = DECODE;
          end else begin
            cnt_nxt = cnt_inc;
            if (time_out) st_nxt = FAULT;
          end
        end
      end
      DECODE: begin
        br_sel   = (opcode == OP_BRA) || (opcode == OP_BNE);
        pc_write = taken;
        pc_sel   = taken;
        unique case (1'b1)
          (is_br || opcode == OP_NOOP):    st_nxt = FETCH;
          (opcode == OP_HLT):              st_nxt = HALT;
          (is_ldst || opcode == OP_ALU):   st_nxt = EXECUTE;
          default:                         st_nxt = FAULT;
        endcase
      end
      EXECUTE: begin
        alu_op = is_ldst ? 2'b11 : {1'b0, is_imm};
        st_nxt = is_ldst ? MEM : WRITEBACK;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STR);
        rb_sel  = (opcode == OP_STR);
        alu_op  = 2'b11;
        if (mem_ack) begin
          cnt_nxt = '0;
          st_nxt  = (opcode == OP_STR) ? FETCH : WRITEBACK;
        end else begin
          cnt_nxt = cnt_inc;
          if (time_out) st_nxt = FAULT;
        end
      end
      WRITEBACK: begin
        rf_we  = 1'b1;
        wb_sel = {1'b0, opcode == OP_LOD};
        alu_op = 2'b10;
        st_nxt = FETCH;
      end
      HALT:  halted = 1'b1;
      FAULT: fault  = 1'b1;
    endcase
    if (st_nxt != st && (st_nxt == FETCH || st_nxt == MEM))
      cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      st  <= START;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: randomized instruction streams checked every cycle against
// a per-instruction trace model, plus directed literal checks.
module tb_ctrl_seq;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_f = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
  logic       run = 1'b0;
  logic       mem_ack = 1'b0;
  logic       rf_we, br_sel, rb_sel, ir_load, pc_sel, pc_write;
  logic       pc_rst, mem_req, mem_we, halted, fault;
  logic [1:0] alu_op, wb_sel;
  logic [2:0] state;

  always #5 clk = ~clk;

  ctrl_seq #(.CC_W(4), .MEM_TIMEOUT(TMO), .WAIT_W(8)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .run(run), .mem_ack(mem_ack), .rf_we(rf_we), .alu_op(alu_op),
    .wb_sel(wb_sel), .br_sel(br_sel), .rb_sel(rb_sel), .ir_load(ir_load),
    .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .fault(fault),
    .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       rf_we;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       br_sel, rb_sel, ir_load, pc_sel, pc_write;
    logic       pc_rst, mem_req, mem_we, halted, fault;
  } exp_t;

  typedef struct {
    bit         rst;
    bit         run;
    bit         ack;
    logic [3:0] op;
    logic [3:0] mm;
    logic [3:0] stat;
    exp_t       e;
  } cyc_t;

  cyc_t       plan_q[$];
  exp_t       obs_q[$];
  logic [3:0] cur_op = 4'd0, cur_mm = 4'd0, cur_stat = 4'd0;
  int         checks = 0;
  int         errors = 0;

  function automatic exp_t at(int s);
    exp_t e;
    e = '0;
    e.st = 3'(s);
    return e;
  endfunction

  function automatic bit rb();
    return 1'($urandom % 2);
  endfunction

  task automatic add(bit rst, bit rn, bit ak, exp_t e);
    cyc_t c;
    c.rst = rst; c.run = rn; c.ack = ak;
    c.op = cur_op; c.mm = cur_mm; c.stat = cur_stat; c.e = e;
    plan_q.push_back(c);
  endtask

  task automatic start_seq(int idle);
    exp_t e;
    e = at(0);
    e.pc_rst = 1'b1;
    add(1'b1, rb(), rb(), e);
    repeat (idle) add(1'b0, 1'b0, rb(), e);
    add(1'b0, 1'b1, rb(), e);
  endtask

  task automatic tail(int s, int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = at(s);
      e.halted = (s == 6);
      e.fault = (s == 7);
      add(1'b0, rb(), rb(), e);
    end
  endtask

  // run=0 cycles are interleaved freely and never count as waiting
  task automatic fetch(int nwait, int nidle, output bit faulted);
    int   w;
    int   idl;
    exp_t e;
    w = 0;
    idl = nidle;
    faulted = 1'b0;
    while (w < nwait || idl > 0) begin
      if (idl > 0 && (w == nwait || rb())) begin
        add(1'b0, 1'b0, rb(), at(1));
        idl--;
      end else begin
        e = at(1);
        e.mem_req = 1'b1;
        add(1'b0, 1'b1, 1'b0, e);
        w++;
        if (w == TMO) begin
          faulted = 1'b1;
          return;
        end
      end
    end
    e = at(1);
    e.mem_req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    add(1'b0, 1'b1, 1'b1, e);
  endtask

  task automatic instr(logic [3:0] op, logic [3:0] m, logic [3:0] s,
                       int fw, int fi, int mw, output bit term);
    bit   f, hit, unc, tk;
    exp_t e;
    term = 1'b0;
    cur_op = op; cur_mm = m; cur_stat = s;
    fetch(fw, fi, f);
    if (f) begin
      tail(7, 3); term = 1'b1; return;
    end
    hit = ((m & s) != 4'd0);
    unc = (m == 4'd0);
    e = at(2);
    if (op >= 4 && op <= 7) begin
      tk = (op <= 5) ? (unc || hit) : (unc || !hit);
      e.br_sel = (op == 4 || op == 6);
      e.pc_write = tk;
      e.pc_sel = tk;
    end
    add(1'b0, rb(), rb(), e);
    if (op == 0 || (op >= 4 && op <= 7)) return;
    if (op == 15) begin
      tail(6, 4); term = 1'b1; return;
    end
    if (!(op == 1 || op == 2 || op == 8)) begin
      tail(7, 3); term = 1'b1; return;
    end
    e = at(3);
    e.alu_op = (op == 8) ? ((m == 4'd8) ? 2'b01 : 2'b00) : 2'b11;
    add(1'b0, rb(), rb(), e);
    if (op != 8) begin
      e = at(4);
      e.mem_req = 1'b1; e.mem_we = (op == 2); e.rb_sel = (op == 2);
      e.alu_op = 2'b11;
      for (int i = 0; i < mw; i++) begin
        add(1'b0, rb(), 1'b0, e);
        if (i + 1 == TMO) begin
          tail(7, 3); term = 1'b1; return;
        end
      end
      add(1'b0, rb(), 1'b1, e);
      if (op == 2) return;
    end
    e = at(5);
    e.rf_we = 1'b1;
    e.wb_sel = (op == 1) ? 2'b01 : 2'b00;
    e.alu_op = 2'b10;
    add(1'b0, rb(), rb(), e);
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run_plan();
    cyc_t c;
    exp_t got;
    int   idx;
    obs_q.delete();
    idx = 0;
    while (plan_q.size() > 0) begin
      c = plan_q.pop_front();
      @(negedge clk);
      rst_f = c.rst; run = c.run; mem_ack = c.ack;
      opcode = c.op; mm = c.mm; stat = c.stat;
      #2;
      got = {state, rf_we, alu_op, wb_sel, br_sel, rb_sel, ir_load,
             pc_sel, pc_write, pc_rst, mem_req, mem_we, halted, fault};
      obs_q.push_back(got);
      checks++;
      if (got !== c.e) begin
        errors++;
        $display("FAIL cycle %0d op=%0d: got=%05h want=%05h",
                 idx, c.op, got, c.e);
      end
      idx++;
    end
  endtask

  function automatic logic [3:0] pick_op();
    int r;
    r = int'($urandom % 32);
    if (r < 24) begin
      case (r % 8)
        0: return 4'd0;  1: return 4'd1;  2: return 4'd2;  3: return 4'd8;
        4: return 4'd4;  5: return 4'd5;  6: return 4'd6;  default: return 4'd7;
      endcase
    end
    if (r < 30) return (r % 3 == 0) ? 4'd1 : ((r % 3 == 1) ? 4'd2 : 4'd8);
    if (r == 30) return 4'd15;
    r = int'($urandom % 7);
    return (r == 0) ? 4'd3 : 4'(8 + r);
  endfunction

  function automatic logic [3:0] pick_mm();
    int r;
    r = int'($urandom % 8);
    if (r < 2) return 4'd0;
    if (r == 2) return 4'd8;
    return 4'($urandom % 16);
  endfunction

  function automatic int rwait();
    return ($urandom % 8 == 0) ? int'(13 + $urandom % 4) : int'($urandom % 3);
  endfunction

  task automatic directed();
    bit t;
    int n0, n1, n2;
    int ds[7] = '{0, 0, 1, 2, 3, 5, 1};
    // ALU_OP with immediate acks
    start_seq(0);
    instr(4'd8, 4'd0, 4'd5, 0, 0, 0, t);
    add(1'b0, 1'b0, 1'b0, at(1));
    run_plan();
    for (int i = 0; i < 7; i++) chk("d1_state", int'(obs_q[i].st), ds[i]);
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 7; i++) begin
      n0 += int'(obs_q[i].ir_load);
      n1 += int'(obs_q[i].pc_write);
      n2 += int'(obs_q[i].rf_we);
    end
    chk("d1_ir_load_count", n0, 1);
    chk("d1_pc_write_count", n1, 1);
    chk("d1_pc_sel", int'(obs_q[2].pc_sel), 0);
    chk("d1_exec_alu_op", int'(obs_q[4].alu_op), 0);
    chk("d1_rf_we_count", n2, 1);
    chk("d1_wb_rf_we", int'(obs_q[5].rf_we), 1);
    // LOD with 3-cycle ack delay, then STR
    start_seq(0);
    instr(4'd1, 4'd3, 4'd1, 0, 0, 3, t);
    instr(4'd2, 4'd3, 4'd1, 0, 0, 0, t);
    add(1'b0, 1'b0, 1'b0, at(1));
    run_plan();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++)
      if (obs_q[i].st == 3'd4 && obs_q[i].mem_req && !obs_q[i].mem_we) n0++;
    for (int i = 10; i < 15; i++) n1 += int'(obs_q[i].rf_we);
    chk("d2_lod_req_cycles", n0, 4);
    chk("d2_lod_wb_sel", int'(obs_q[9].wb_sel), 1);
    chk("d2_lod_rf_we", int'(obs_q[9].rf_we), 1);
    chk("d2_str_we_rb", int'({obs_q[13].mem_we, obs_q[13].rb_sel}), 3);
    chk("d2_str_to_fetch", int'(obs_q[14].st), 1);
    chk("d2_str_no_rf_we", n1, 0);
    // branches
    start_seq(0);
    instr(4'd4, 4'b0100, 4'b0100, 0, 0, 0, t);
    instr(4'd7, 4'b0100, 4'b0100, 0, 0, 0, t);
    instr(4'd6, 4'b0000, 4'b1010, 0, 0, 0, t);
    add(1'b0, 1'b0, 1'b0, at(1));
    run_plan();
    chk("d3_bra", int'({obs_q[3].pc_write, obs_q[3].pc_sel, obs_q[3].br_sel}), 7);
    chk("d3_bnr", int'({obs_q[5].pc_write, obs_q[5].br_sel}), 0);
    chk("d3_bne_uncond", int'({obs_q[7].pc_write, obs_q[7].br_sel}), 3);
    chk("d3_ret_fetch", int'(obs_q[4].st), 1);
    chk("d3_ret_fetch2", int'(obs_q[8].st), 1);
    // fetch timeout, then ack on the last allowed cycle
    start_seq(0);
    instr(4'd8, 4'd0, 4'd0, 20, 0, 0, t);
    run_plan();
    n0 = 0;
    for (int i = 0; i < obs_q.size(); i++)
      if (obs_q[i].st == 3'd1 && obs_q[i].mem_req) n0++;
    chk("d4_wait_cycles", n0, 15);
    chk("d4_fault_state", int'(obs_q[17].st), 7);
    chk("d4_fault_sticky", int'(obs_q[19].fault), 1);
    start_seq(0);
    instr(4'd8, 4'd0, 4'd0, 14, 0, 0, t);
    run_plan();
    chk("d4_ack_wins", int'(obs_q[17].st), 2);
    // HLT, illegal opcode, reset mid-MEM
    start_seq(0);
    instr(4'd15, 4'd0, 4'd0, 0, 0, 0, t);
    start_seq(0);
    instr(4'd3, 4'd0, 4'd0, 0, 0, 0, t);
    start_seq(0);
    instr(4'd1, 4'd2, 4'd2, 0, 0, 5, t);
    while (plan_q.size() > 23) plan_q.delete(plan_q.size() - 1);
    begin
      exp_t e;
      e = at(0);
      e.pc_rst = 1'b1;
      add(1'b1, 1'b0, 1'b0, e);
      add(1'b0, 1'b0, 1'b0, e);
      add(1'b0, 1'b0, 1'b0, e);
    end
    run_plan();
    n0 = 0;
    for (int i = 4; i < 8; i++) n0 += int'(obs_q[i].mem_req);
    chk("d5_halted", int'(obs_q[4].halted), 1);
    chk("d5_halt_no_req", n0, 0);
    chk("d5_halt_state", int'(obs_q[7].st), 6);
    chk("d5_illegal_fault", int'(obs_q[12].st), 7);
    chk("d5_pre_rst_req", int'(obs_q[22].mem_req), 1);
    chk("d5_rst_drop", int'({obs_q[23].st, obs_q[23].mem_req, obs_q[23].pc_rst}), 1);
    chk("d5_hold_start", int'(obs_q[25].st), 0);
  endtask

  initial begin
    bit t;
    int base;
    int len;
    directed();
    for (int ep = 0; ep < 40; ep++) begin
      base = plan_q.size();
      start_seq(int'($urandom % 3));
      for (int k = 0; k < 8; k++) begin
        instr(pick_op(), pick_mm(), 4'($urandom % 16),
              rwait(), int'($urandom % 3), rwait(), t);
        if (t) break;
      end
      if ($urandom % 3 == 0) begin
        len = plan_q.size() - base;
        len = base + 1 + int'($urandom % len);
        while (plan_q.size() > len) plan_q.delete(plan_q.size() - 1);
      end
      run_plan();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
